byte_unstriping: RTL
====================

// Module: byte_unstriping
// PURPOSE
//  Receive-side counterpart of the lane byte striper. Collects a serial byte stream
//  (one byte per accepted clk cycle) and rebuilds 8-, 16- or 32-bit words.
//  Sits between the lane byte stream and the wide-datapath consumer.
//  Byte order is MSB-first: the first byte of a word lands in its most significant byte.
// PARAMETERS
//  BYTE_W   8   width of one input byte; fixed, do not override
//  MODE_W   2   width of mode select S
// PORTS
//  clk         in   1   single clock, all logic on posedge
//  reset       in   1   synchronous, active-low reset (0 = reset)
//  enb         in   1   block enable; 0 freezes all state
//  valid_in    in   1   entrada carries a byte this cycle
//  entrada     in   8   input byte
//  S           in   2   mode: 00/11 = 8 bit, 01 = 16 bit, 10 = 32 bit
//  salida8     out  8   last completed 8-bit word
//  salida16    out  16  last completed 16-bit word
//  salida32    out  32  last completed 32-bit word
//  valid_out   out  1   1-cycle pulse: salidaN for the current S was just updated
//  parcial     out  1   1 = a partial word is held (contador != 0)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): contador=0, shift reg=0, salida8/16/32=0,
//    valid_out=0, parcial=0, S_q=00. Overrides everything, including mid-word.
//  - Byte accepted when enb && valid_in at posedge.
//  - N = 1 (S=00/11), 2 (S=01), 4 (S=10). contador is 2 bits, range 0..N-1.
//  - Accept with contador < N-1: shift byte into the accumulator, contador+1.
//  - Accept with contador == N-1: register the full word {acc, entrada} into the
//    salidaN matching S, valid_out=1 next cycle, contador returns to 0.
//  - Latency: valid_out/salidaN update on the posedge that accepts the last byte.
//    This makes the result visible 1 cycle after the last byte is presented.
//    8-bit mode: every accepted byte is a complete word.
//  - Outputs of the non-selected widths hold their previous values.
//    valid_out refers only to the active mode.
//  - Gaps (valid_in=0, enb=1): contador and accumulator hold; valid_out=0.
//  - enb=0: all state frozen; valid_out forced 0.
//  - S registered as S_q every enabled cycle. If S != S_q, the partial word is
//    discarded (contador=0). A byte accepted that same cycle counts as byte 0 of
//    the new mode; with S=00 it completes immediately.
//  - S=11 treated exactly as 00.
//  - parcial = (contador != 0), registered with contador.
// STRUCTURE
//  - Shared package/include: mode constants MODE_8=2'b00, MODE_16=2'b01,
//    MODE_32=2'b10, and function bytes_per_word(S) -> 1/2/4.
//    The striper uses the same package.
//  - One natural sub-module: unstrip_acc (24-bit MSB-first shift accumulator
//    with load/clear).
//  - Counter, mode-change detect and output registers stay in the top module.
// TESTING
//  1. Reset held 2 cycles, then released with no traffic
//     -> all outputs 0, valid_out stays 0.
//  2. S=01, bytes AB, CD on consecutive cycles
//     -> salida16=16'hABCD, valid_out 1 for exactly one cycle, parcial 1 then 0.
//  3. S=10, bytes 11, 22, (valid_in=0 for 2 cycles), 33, 44
//     -> salida32=32'h11223344 with a single valid_out pulse; salida16 unchanged.
//  4. S=00, bytes 5A, A5 -> salida8=5A then A5, valid_out high both cycles.
//  5. S=10, bytes DE, AD, then S->01 and bytes BE, EF
//     -> partial discarded, salida16=16'hBEEF, salida32 still 0.
//  6. S=10, bytes 01, 02, reset low one cycle, then 03, 04, 05, 06
//     -> salida32=32'h03040506; enb=0 mid-word freezes contador and parcial.

Source files
------------

// File: rtl/byte_unstriping_pkg.sv
// Shared lane-striping definitions: mode codes
// and bytes-per-word lookup (striper and unstriper).
package byte_unstriping_pkg;

  localparam logic [1:0] MODE_8  = 2'b00;
  localparam logic [1:0] MODE_16 = 2'b01;
  localparam logic [1:0] MODE_32 = 2'b10;

  // 2'b11 aliases the 8-bit mode
  function automatic logic [1:0] norm_mode(
    input logic [1:0] s
  );
    return (s == 2'b11) ? MODE_8 : s;
  endfunction

  function automatic logic [2:0] bytes_per_word(
    input logic [1:0] s
  );
    logic [2:0] n;
    n = 3'd1;
    unique case (1'b1)
      (s == MODE_16): n = 3'd2;
      (s == MODE_32): n = 3'd4;
      default:        n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/unstrip_acc.sv
// 24-bit MSB-first byte shift accumulator.
// Ports: clk, reset(sync low), clr, shift, din, acc.
module unstrip_acc (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic [23:0] acc
);

  // clr+shift starts a fresh word with din
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= shift ? {16'h0, din} : 24'h0;
    end else if (shift) begin
      acc <= {acc[15:0], din};
    end
  end

endmodule

// File: rtl/byte_unstriping.sv
// Rebuilds 8/16/32-bit words from a byte stream.
// Ports: clk, reset, enb, valid_in, entrada, S ->
//   salida8/16/32, valid_out, parcial.
module byte_unstriping
  import byte_unstriping_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int MODE_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic              valid_in,
  input  logic [BYTE_W-1:0] entrada,
  input  logic [MODE_W-1:0] S,
  output logic [7:0]        salida8,
  output logic [15:0]       salida16,
  output logic [31:0]       salida32,
  output logic              valid_out,
  output logic              parcial
);

  logic [1:0]  cnt;
  logic [1:0]  cnt_eff;
  logic [1:0]  cnt_nxt;
  logic [1:0]  s_q;
  logic [1:0]  sn;
  logic [2:0]  n;
  logic        mode_chg;
  logic        accept;
  logic        last;
  logic        acc_clr;
  logic        acc_shift;
  logic [23:0] acc;

  assign sn       = norm_mode(S);
  assign n        = bytes_per_word(sn);
  assign mode_chg = (sn != s_q);
  // a mode switch drops the partial word
  assign cnt_eff  = mode_chg ? 2'd0 : cnt;
  assign accept   = enb & valid_in;
  assign last     = ({1'b0, cnt_eff} == n - 3'd1);

  assign acc_clr   = enb & (mode_chg | (accept & last));
  assign acc_shift = accept & ~last;

  always_comb begin
    cnt_nxt = cnt_eff;
    if (accept) begin
      cnt_nxt = last ? 2'd0 : cnt_eff + 2'd1;
    end
  end

  unstrip_acc u_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr),
    .shift (acc_shift),
    .din   (entrada),
    .acc   (acc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      s_q       <= MODE_8;
      salida8   <= '0;
      salida16  <= '0;
      salida32  <= '0;
      valid_out <= 1'b0;
      parcial   <= 1'b0;
    end else if (enb) begin
      s_q       <= sn;
      cnt       <= cnt_nxt;
      parcial   <= (cnt_nxt != 2'd0);
      valid_out <= accept & last;
      if (accept && last) begin
        unique case (1'b1)
          (sn == MODE_32): salida32 <= {acc, entrada};
          (sn == MODE_16): salida16 <= {acc[7:0], entrada};
          default:         salida8  <= entrada;
        endcase
      end
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule
